// File: rtl/lcd_seq_pkg.sv
// Shared definitions for the LCD ROM sequencer: FSM states, ROM entry fields and wait selection.
package lcd_seq_pkg;

  typedef enum logic [2:0] {
    StPor   = 3'd0,
    StFetch = 3'd1,
    StSetup = 3'd2,
    StEhi   = 3'd3,
    StHold  = 3'd4,
    StWait  = 3'd5,
    StDone  = 3'd6
  } lcd_state_e;

  localparam int unsigned RS_BIT  = 4;
  localparam int unsigned NIB_MSB = 3;
  localparam int unsigned NIB_LSB = 0;

  localparam logic [5:0] LAST_ADDR = 6'd63;

  // The first init_len entries are power-up commands that need the long settle time.
  function automatic int unsigned wait_cycles(input logic [5:0]  addr,
                                              input int unsigned init_len,
                                              input int unsigned init_cyc,
                                              input int unsigned gap_cyc);
    return (32'(addr) < init_len) ? init_cyc : gap_cyc;
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter that saturates at zero; zero_o flags the final cycle of a timed state.
module lcd_delay_cnt #(
  parameter int unsigned CNT_W = 18
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_rom_sequencer.sv
// Replays a 64-entry command/text ROM onto a 4-bit HD44780 bus, one enable-strobed nibble per entry.
module lcd_rom_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned POR_CYC   = 200000,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned E_CYC     = 5,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned GAP_CYC   = 400,
  parameter int unsigned INIT_LEN  = 2,
  parameter int unsigned INIT_CYC  = 50000,
  parameter int unsigned CNT_W     = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [5:0] rom_addr,
  input  logic [7:0] rom_q,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_d,
  output logic       busy,
  output logic       done
);

  // Reset leaves the counter at 0, so POR spends its first cycle loading POR_CYC-2.
  localparam logic [CNT_W-1:0] PorLd   = CNT_W'(POR_CYC - 2);
  localparam logic [CNT_W-1:0] SetupLd = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EhiLd   = CNT_W'(E_CYC - 1);
  localparam logic [CNT_W-1:0] HoldLd  = CNT_W'(HOLD_CYC - 1);

  lcd_state_e       state_q, state_d;
  logic [5:0]       addr_q, addr_d;
  logic             rs_q, rs_d;
  logic [3:0]       nib_q, nib_d;
  logic             e_q;
  logic             busy_q;
  logic             done_q;
  logic             por_armed_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             unused_rom_hi;

  assign unused_rom_hi = ^rom_q[7:5];

  lcd_delay_cnt #(
    .CNT_W (CNT_W)
  ) u_delay_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rs_d     = rs_q;
    nib_d    = nib_q;
    cnt_load = 1'b0;
    cnt_val  = '0;

    unique case (state_q)
      StPor: begin
        if (!por_armed_q && (POR_CYC > 1)) begin
          cnt_load = 1'b1;
          cnt_val  = PorLd;
        end else if (cnt_zero) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        rs_d    = rom_q[RS_BIT];
        nib_d   = rom_q[NIB_MSB:NIB_LSB];
        state_d = StSetup;
      end
      StSetup: if (cnt_zero) state_d = StEhi;
      StEhi:   if (cnt_zero) state_d = StHold;
      StHold:  if (cnt_zero) state_d = StWait;
      StWait: begin
        if (cnt_zero) begin
          if (addr_q == LAST_ADDR) begin
            state_d = StDone;
          end else begin
            addr_d  = addr_q + 6'd1;
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        if (start) begin
          addr_d  = '0;
          state_d = StFetch;
        end
      end
      default: state_d = StPor;
    endcase

    // Every state entry loads its length minus one; FETCH and DONE load zero.
    if (state_d != state_q) begin
      cnt_load = 1'b1;
      unique case (state_d)
        StSetup: cnt_val = SetupLd;
        StEhi:   cnt_val = EhiLd;
        StHold:  cnt_val = HoldLd;
        StWait:  cnt_val = CNT_W'(wait_cycles(addr_q, INIT_LEN, INIT_CYC, GAP_CYC) - 1);
        default: cnt_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StPor;
      addr_q      <= '0;
      rs_q        <= 1'b0;
      nib_q       <= '0;
      e_q         <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      por_armed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rs_q        <= rs_d;
      nib_q       <= nib_d;
      e_q         <= (state_d == StEhi);
      busy_q      <= (state_d != StDone);
      done_q      <= (state_d == StDone);
      por_armed_q <= 1'b1;
    end
  end

  assign rom_addr = addr_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = e_q;
  assign lcd_d    = nib_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_lcd_rom_sequencer.sv
// Bench for lcd_rom_sequencer: randomized ROM contents, schedule-based reference model, literal pins.
module tb_lcd_rom_sequencer;

  localparam int unsigned POR     = 10;
  localparam int unsigned SETUP   = 1;
  localparam int unsigned ECYC    = 2;
  localparam int unsigned HOLD    = 1;
  localparam int unsigned GAP     = 3;
  localparam int unsigned INITLEN = 2;
  localparam int unsigned INITC   = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] rom_addr;
  logic [7:0] rom_q;
  logic       lcd_rs, lcd_rw, lcd_e, busy, done;
  logic [3:0] lcd_d;

  logic [7:0] rom [64];
  assign rom_q = rom[rom_addr];

  always #5 clk = ~clk;

  lcd_rom_sequencer #(
    .POR_CYC   (POR),
    .SETUP_CYC (SETUP),
    .E_CYC     (ECYC),
    .HOLD_CYC  (HOLD),
    .GAP_CYC   (GAP),
    .INIT_LEN  (INITLEN),
    .INIT_CYC  (INITC),
    .CNT_W     (18)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_d    (lcd_d),
    .busy     (busy),
    .done     (done)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Entry schedule: each entry lasts 1 + setup + E + hold + wait cycles.
  int ent_start[65];
  int total;

  // Reference model: either counting POR cycles or at run-time index m_t into the schedule.
  logic       m_run;
  int         m_por;
  int         m_t;
  logic       m_pre_rs;
  logic [3:0] m_pre_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_por <= 0; m_t <= 0; m_pre_rs <= 1'b0; m_pre_d <= 4'h0;
    end else if (!m_run) begin
      m_por <= m_por + 1;
      if (m_por + 1 == int'(POR)) begin
        m_run <= 1'b1;
        m_t   <= 0;
      end
    end else if (m_t >= total) begin
      if (start) begin
        m_t      <= 0;
        m_pre_rs <= rom[63][4];
        m_pre_d  <= rom[63][3:0];
      end
    end else begin
      m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin : cmp
    logic       ee, ers, eb, edn;
    logic [3:0] ed;
    logic [5:0] ea;
    int         k, o;
    if (rst_n) begin
      if (!m_run) begin
        ee = 1'b0; ers = 1'b0; ed = 4'h0; ea = 6'd0; eb = 1'b1; edn = 1'b0;
      end else if (m_t >= total) begin
        ee = 1'b0; ers = rom[63][4]; ed = rom[63][3:0]; ea = 6'd63; eb = 1'b0; edn = 1'b1;
      end else begin
        k = 0;
        for (int i = 0; i < 64; i++) if (m_t >= ent_start[i]) k = i;
        o  = m_t - ent_start[k];
        ee = (o >= 1 + int'(SETUP)) && (o < 1 + int'(SETUP + ECYC));
        if (o >= 1) begin
          ers = rom[k][4]; ed = rom[k][3:0];
        end else if (k > 0) begin
          ers = rom[k-1][4]; ed = rom[k-1][3:0];
        end else begin
          ers = m_pre_rs; ed = m_pre_d;
        end
        ea = 6'(k); eb = 1'b1; edn = 1'b0;
      end
      check("model_lcd_e", lcd_e, ee);
      check("model_lcd_rs", lcd_rs, ers);
      check("model_lcd_d", lcd_d, ed);
      check("model_rom_addr", rom_addr, ea);
      check("model_busy", busy, eb);
      check("model_done", done, edn);
      check("model_lcd_rw", lcd_rw, 1'b0);
    end
  end

  // Pulse monitor: rise cycle (counted from reset release), address, RS/D and width per pulse.
  int         rel_cyc;
  int         n_rise = 0;
  int         cur_w = 0;
  logic       prev_e = 1'b0;
  int         rise_cyc [256];
  logic [5:0] rise_addr [256];
  logic       rise_rs [256];
  logic [3:0] rise_d [256];
  int         rise_w [256];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rel_cyc <= 0;
    else        rel_cyc <= rel_cyc + 1;
  end

  always @(negedge clk) begin
    if (lcd_e && !prev_e && n_rise < 256) begin
      rise_cyc[n_rise]  <= rel_cyc;
      rise_addr[n_rise] <= rom_addr;
      rise_rs[n_rise]   <= lcd_rs;
      rise_d[n_rise]    <= lcd_d;
      n_rise            <= n_rise + 1;
      cur_w             <= 1;
    end else if (lcd_e) begin
      cur_w <= cur_w + 1;
    end
    if (!lcd_e && prev_e && n_rise > 0) rise_w[n_rise-1] <= cur_w;
    prev_e <= lcd_e;
  end

  task automatic wait_rises(input int target, input int budget, input string name);
    for (int i = 0; i < budget && n_rise < target; i++) begin
      @(negedge clk);
      #1;
    end
    check(name, n_rise, target);
  endtask

  initial begin
    int base;
    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
    rom[0] = 8'hE3;
    rom[8] = 8'h14;
    ent_start[0] = 0;
    for (int k = 0; k < 64; k++)
      ent_start[k+1] = ent_start[k] + int'(1 + SETUP + ECYC + HOLD)
                     + ((k < int'(INITLEN)) ? int'(INITC) : int'(GAP));
    total = ent_start[64];

    repeat (3) @(negedge clk);
    #1;
    check("rst_lcd_e", lcd_e, 1'b0);
    check("rst_lcd_rs", lcd_rs, 1'b0);
    check("rst_lcd_d", lcd_d, 4'h0);
    check("rst_rom_addr", rom_addr, 6'd0);
    check("rst_busy", busy, 1'b1);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;

    // Start pulse during entry 20 must be ignored.
    wait_rises(21, 600, "reach_entry20");
    start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;

    for (int i = 0; i < 1000 && done !== 1'b1; i++) begin
      @(negedge clk);
      #1;
    end
    check("done_reached", done, 1'b1);
    check("pulse_count", n_rise, 64);
    check("done_busy", busy, 1'b0);
    check("done_addr", rom_addr, 6'd63);
    check("first_rise_cyc", rise_cyc[0], 12);
    check("first_rise_d", rise_d[0], 4'h3);
    check("first_rise_rs", rise_rs[0], 1'b0);
    check("spacing_0_1", rise_cyc[1] - rise_cyc[0], 11);
    check("spacing_1_2", rise_cyc[2] - rise_cyc[1], 11);
    check("spacing_2_3", rise_cyc[3] - rise_cyc[2], 8);
    check("entry8_addr", rise_addr[8], 6'd8);
    check("entry8_rs", rise_rs[8], 1'b1);
    check("entry8_d", rise_d[8], 4'h4);
    check("entry8_width", rise_w[8], 2);

    // Restart from DONE: no POR, E rises two cycles after the start pulse.
    repeat (3) @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    check("restart_fetch_e", lcd_e, 1'b0);
    check("restart_addr", rom_addr, 6'd0);
    @(negedge clk);
    #1 check("restart_setup_e", lcd_e, 1'b0);
    @(negedge clk);
    #1 check("restart_rise_e", lcd_e, 1'b1);
    check("restart_rise_addr", rom_addr, 6'd0);

    // Asynchronous reset in the middle of entry 30's enable pulse.
    for (int i = 0; i < 800 && !(lcd_e === 1'b1 && rom_addr == 6'd30); i++) begin
      @(negedge clk);
      #1;
    end
    check("reach_e30_addr", rom_addr, 6'd30);
    check("reach_e30_e", lcd_e, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midpulse_rst_e", lcd_e, 1'b0);
    check("midpulse_rst_addr", rom_addr, 6'd0);
    check("midpulse_rst_rs", lcd_rs, 1'b0);
    check("midpulse_rst_d", lcd_d, 4'h0);
    check("midpulse_rst_busy", busy, 1'b1);
    check("midpulse_rst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    base = n_rise;
    wait_rises(base + 1, 100, "post_rst_rise");
    check("post_rst_rise_cyc", rise_cyc[base], 12);
    check("post_rst_rise_addr", rise_addr[base], 6'd0);
    check("post_rst_rise_d", rise_d[base], 4'h3);
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
